// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin owner of the register file write port (we3/a3/wd3).
//
// NUM_REQ writeback sources (ALU, load unit, CSR/mul, ...) compete for the single
// write port through a valid/ready handshake. A granted write is registered and
// presented on we3/a3/wd3 for exactly one cycle; the register file captures it on
// the following edge. Writes to x0 are accepted but never reach the port.
//
// Optional feature macro: RF_WB_INIT_CLEAR_EN
//   defined   : after every reset the block first writes zero to x1..x31
//               (31 cycles, requesters stalled, init_busy high).
//   undefined : arbitration starts in the first cycle after reset and
//               init_busy is tied low.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester write request
//   req_addr   destination registers, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  one-hot grant (combinational)
//   we3        register file write enable (registered)
//   a3         register file write address (registered)
//   wd3        register file write data (registered)
//   init_busy  clear sequence in progress (registered)
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      we3,
    output logic [ADDR_W-1:0]         a3,
    output logic [DATA_W-1:0]         wd3,
    output logic                      init_busy
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      scan_idx;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_found;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [ADDR_W-1:0]  gnt_addr;
    logic [DATA_W-1:0]  gnt_data;
    logic               arb_active;
    logic               hs;

    // Search starts one past the last winner and wraps, so the most recent
    // winner has the lowest priority on the next cycle.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        gnt_oh   = '0;
        gnt_addr = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_found && gnt_idx == PW'(i)) begin
                gnt_oh[i] = 1'b1;
                gnt_addr  = req_addr[i*ADDR_W +: ADDR_W];
                gnt_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = arb_active ? gnt_oh : '0;
    assign hs        = arb_active & gnt_found;

`ifdef RF_WB_INIT_CLEAR_EN
    typedef enum logic {INIT, ARB} state_e;

    localparam logic [ADDR_W-1:0] LAST_REG = '1;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;

    // state_q is forced to INIT by reset, which also keeps req_ready low then.
    assign arb_active = (state_q == ARB);
`else
    // Without the clear sequence the only thing holding grants off is reset.
    assign arb_active = rst_n;
    assign init_busy  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= PW'(NUM_REQ - 1);
            we3       <= 1'b0;
            a3        <= '0;
            wd3       <= '0;
`ifdef RF_WB_INIT_CLEAR_EN
            state_q   <= INIT;
            cnt_q     <= ADDR_W'(1);
            init_busy <= 1'b1;
`endif
        end
`ifdef RF_WB_INIT_CLEAR_EN
        else if (state_q == INIT) begin
            we3   <= 1'b1;
            a3    <= cnt_q;
            wd3   <= '0;
            cnt_q <= cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_REG) begin
                state_q   <= ARB;
                init_busy <= 1'b0;
            end
        end
`endif
        else begin
            // x0 writes are consumed and still rotate the pointer, but never
            // reach the port; a3/wd3 only change when a real write is issued.
            we3 <= hs && (gnt_addr != '0);
            if (hs) begin
                ptr_q <= gnt_idx;
                if (gnt_addr != '0) begin
                    a3  <= gnt_addr;
                    wd3 <= gnt_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: randomized self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
    localparam int N    = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int LAST = 31;
`ifdef RF_WB_INIT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          we3;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    logic          init_busy;

    rf_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .we3(we3), .a3(a3), .wd3(wd3), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: last winner, clear progress, expected port contents.
    int            last_g;
    int            clear_next;
    logic          m_we;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd;
    logic          m_busy;
    logic [DW-1:0] m_rf [32];
    logic          m_rf_ok [32];
    int            wait_cnt [N];
    logic [N-1:0]  hs_last = '0;

    // Register file as the real consumer of the write port sees it.
    logic [DW-1:0] dut_rf [32];
    logic          x0_hit = 1'b0;
    always @(posedge clk)
        if (rst_n && we3) begin
            dut_rf[a3] <= wd3;
            if (a3 == '0) x0_hit <= 1'b1;
        end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        last_g     = N - 1;
        clear_next = CLR ? 1 : LAST + 1;
        m_we       = 1'b0;
        m_a3       = '0;
        m_wd       = '0;
        m_busy     = CLR;
        hs_last    = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    // Grant rule: first valid requester after the last winner, wrapping.
    function automatic logic [N-1:0] exp_ready();
        if (!rst_n || clear_next <= LAST) return '0;
        for (int k = 1; k <= N; k++) begin
            int j = (last_g + k) % N;
            if (req_valid[j]) return N'(1) << j;
        end
        return '0;
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_we3"}, we3, 0);
        chk({tag, "_a3"}, a3, 0);
        chk({tag, "_wd3"}, wd3, 0);
        chk({tag, "_busy"}, init_busy, CLR);
        chk({tag, "_ready"}, req_ready, 0);
    endtask

    // One clock cycle: inputs already driven (just after a falling edge).
    task automatic step();
        logic [N-1:0]  er;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int g;
        #1;
        er = exp_ready();
        chk("req_ready", req_ready, er);
        if (clear_next > LAST)
            for (int i = 0; i < N; i++) begin
                wait_cnt[i] = (req_valid[i] && !req_ready[i]) ? wait_cnt[i] + 1 : 0;
                chk("fair_wait", wait_cnt[i] >= N, 0);
            end
        hs_last = er;
        if (m_we) begin
            m_rf[m_a3]    = m_wd;
            m_rf_ok[m_a3] = 1'b1;
        end
        g = -1;
        for (int i = 0; i < N; i++) if (er[i]) g = i;
        if (clear_next <= LAST) begin
            m_we = 1'b1;
            m_a3 = AW'(clear_next);
            m_wd = '0;
            clear_next++;
        end else if (g >= 0) begin
            a = AW'(req_addr >> (g * AW));
            d = DW'(req_data >> (g * DW));
            m_we = (a != '0);
            if (m_we) begin
                m_a3 = a;
                m_wd = d;
            end
            last_g = g;
        end else begin
            m_we = 1'b0;
        end
        m_busy = (clear_next <= LAST);
        @(posedge clk);
        @(negedge clk);
        chk("we3", we3, m_we);
        chk("a3", a3, m_a3);
        chk("wd3", wd3, m_wd);
        chk("init_busy", init_busy, m_busy);
    endtask

    // Requests already pending must hold until their handshake.
    task automatic drive_random(input int pv);
        for (int i = 0; i < N; i++)
            if (!req_valid[i] || hs_last[i]) begin
                req_valid[i] = ($urandom_range(99) < pv);
                req_addr[i*AW +: AW] = ($urandom_range(7) == 0) ? '0 : AW'($urandom);
                req_data[i*DW +: DW] = $urandom;
            end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_rf_ok[i] = 1'b0;
        model_reset();

        // All requesters valid across reset release: x5=A, x6=B, x7=C.
        req_valid = '1;
        req_addr  = {5'd7, 5'd6, 5'd5};
        req_data  = {32'hC, 32'hB, 32'hA};
        repeat (2) @(negedge clk);
        #2 reset_checks("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("first_ready", req_ready, CLR ? 3'b000 : 3'b001);
        repeat (CLR ? LAST : 0) step();
        chk("clear_end_a3", a3, CLR ? 31 : 0);
        chk("clear_end_we3", we3, CLR ? 1 : 0);
        chk("clear_end_busy", init_busy, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_a3", a3, 5 + k % 3);
            chk("rr_wd3", wd3, 32'hA + k % 3);
        end
        repeat (N) begin
            req_valid &= ~hs_last;
            step();
        end

        // Write to x0 from requester 1: granted, consumed, never written.
        req_valid = 3'b010;
        req_addr[AW +: AW] = '0;
        req_data[DW +: DW] = 32'hDEADBEEF;
        #1 chk("x0_ready", req_ready, 3'b010);
        step();
        chk("x0_we3", we3, 0);
        req_valid = '0;
        step();

        // Requester 2 wins, then requester 0 outranks its repeat request.
        req_valid = 3'b100;
        req_addr[2*AW +: AW] = 5'd9;
        req_data[2*DW +: DW] = 32'h99;
        step();
        chk("p2_a3", a3, 9);
        req_valid = 3'b101;
        req_addr[0 +: AW] = 5'd4;
        req_data[0 +: DW] = 32'h44;
        #1 chk("p0_ready", req_ready, 3'b001);
        step();
        chk("p0_a3", a3, 4);
        chk("p0_wd3", wd3, 32'h44);
        req_valid = 3'b100;
        step();
        chk("p2b_a3", a3, 9);
        req_valid = '0;
        step();

        // Reset pulsed mid-clear (a3=12 presented), sequence restarts at x1.
        rst_n = 1'b0;
        #2 model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            drive_random(80);
            step();
        end
        #2 rst_n = 1'b0;
        #1 reset_checks("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (CLR ? LAST : 0) begin
            drive_random(80);
            step();
        end
        chk("restart_a3", a3, CLR ? 31 : 0);

        // Random traffic at several load levels.
        for (int n = 0; n < 600; n++) begin
            drive_random(n < 200 ? 95 : (n < 400 ? 45 : 15));
            step();
        end

        for (int i = 1; i < 32; i++)
            if (m_rf_ok[i]) chk("rf_read", dut_rf[i], m_rf[i]);
        chk("x0_untouched", x0_hit, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
